reg_bank_reader: RTL and testbench

- Register bank that consumes the destination index chosen by the write-register mux (rt, rd, or 31/$ra) and provides the read side of the datapath.
- 32 x 32-bit general registers, two combinational read ports, one synchronous write port.
- Built-in A/B operand latches feed the ALU-source muxes in the multicycle MIPS datapath.
- Sits between the instruction register fields and the ALU; written back by the control unit's RegWrite step.

---
 rtl/reg_bank_reader.sv | 85 ++++++++
 tb/tb_reg_bank_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_reader.sv
// 32-entry register bank with two combinational read ports, one write port,
// optional write-to-read forwarding and registered A/B operand latches.
module reg_bank_reader #(
  parameter int DATA_W  = 32,
  parameter int SP_INIT = 227,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic              load_ab,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              ab_valid
);

  localparam logic [4:0] SP_IDX = 5'd29;

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              v_q, v_d;
  logic              wr_en;
  logic              hit1, hit2;

  assign wr_en = reg_write && (write_reg != 5'd0);
  assign hit1  = BYPASS && wr_en && (write_reg == read_reg1);
  assign hit2  = BYPASS && wr_en && (write_reg == read_reg2);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        if (5'(i) == SP_IDX)
          regs_q[i] <= DATA_W'(SP_INIT);
        else
          regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // r0 is forced to zero here, so its storage slot never matters
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_reg1 != 5'd0)
      read_data1 = hit1 ? write_data : regs_q[read_reg1];
    if (read_reg2 != 5'd0)
      read_data2 = hit2 ? write_data : regs_q[read_reg2];
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    v_d = load_ab;
    if (load_ab) begin
      a_d = read_data1;
      b_d = read_data2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      v_q <= v_d;
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign ab_valid = v_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench: one bank with forwarding and one without,
// driven by the same stimulus.
module tb_reg_bank_reader;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        load_ab;

  logic [31:0] rd1_b, rd2_b, a_b, b_b;
  logic        v_b;
  logic [31:0] rd1_n, rd2_n, a_n, b_n;
  logic        v_n;

  int n_chk;
  int n_fail;

  reg_bank_reader #(.DATA_W(32), .SP_INIT(227), .BYPASS(1'b1)) u_byp (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .load_ab    (load_ab),
    .read_data1 (rd1_b),
    .read_data2 (rd2_b),
    .a_out      (a_b),
    .b_out      (b_b),
    .ab_valid   (v_b)
  );

  reg_bank_reader #(.DATA_W(32), .SP_INIT(227), .BYPASS(1'b0)) u_nob (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .load_ab    (load_ab),
    .read_data1 (rd1_n),
    .read_data2 (rd2_n),
    .a_out      (a_n),
    .b_out      (b_n),
    .ab_valid   (v_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ab(input string tag,
                        input logic [31:0] ea,
                        input logic [31:0] eb,
                        input logic ev);
    chk({tag, " a byp"}, a_b, ea);
    chk({tag, " b byp"}, b_b, eb);
    chk({tag, " v byp"}, {31'd0, v_b}, {31'd0, ev});
    chk({tag, " a nob"}, a_n, ea);
    chk({tag, " b nob"}, b_n, eb);
    chk({tag, " v nob"}, {31'd0, v_n}, {31'd0, ev});
  endtask

  initial begin
    logic [31:0] e1, e2, pa, pb;
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'd0;
    read_reg1  = 5'd0;
    read_reg2  = 5'd0;
    load_ab    = 1'b0;

    // reset state
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      e1 = (i == 29) ? 32'd227 : 32'd0;
      e2 = (31 - i == 29) ? 32'd227 : 32'd0;
      #1;
      chk($sformatf("rst r%0d p1 byp", i), rd1_b, e1);
      chk($sformatf("rst r%0d p2 byp", 31 - i), rd2_b, e2);
      chk($sformatf("rst r%0d p1 nob", i), rd1_n, e1);
    end
    chk_ab("rst", 32'd0, 32'd0, 1'b0);

    // write r8, attempted write r0
    reg_write  = 1'b1;
    write_reg  = 5'd8;
    write_data = 32'hDEADBEEF;
    step();
    write_reg  = 5'd0;
    write_data = 32'h12345678;
    read_reg1  = 5'd0;
    #1;
    chk("r0 bypass byp", rd1_b, 32'd0);
    step();
    reg_write = 1'b0;
    read_reg1 = 5'd8;
    read_reg2 = 5'd0;
    #1;
    chk("r8 byp", rd1_b, 32'hDEADBEEF);
    chk("r0 byp", rd2_b, 32'd0);
    chk("r8 nob", rd1_n, 32'hDEADBEEF);
    chk("r0 nob", rd2_n, 32'd0);

    // same-cycle write and capture of r5
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'hA5A5A5A5;
    read_reg1  = 5'd5;
    read_reg2  = 5'd5;
    load_ab    = 1'b1;
    #1;
    chk("fwd p1 byp", rd1_b, 32'hA5A5A5A5);
    chk("fwd p2 byp", rd2_b, 32'hA5A5A5A5);
    chk("fwd p1 nob", rd1_n, 32'd0);
    step();
    reg_write = 1'b0;
    load_ab   = 1'b0;
    chk("fwd a byp", a_b, 32'hA5A5A5A5);
    chk("fwd b byp", b_b, 32'hA5A5A5A5);
    chk("fwd a nob", a_n, 32'd0);
    chk("fwd v byp", {31'd0, v_b}, 32'd1);
    chk("r5 after nob", rd1_n, 32'hA5A5A5A5);
    step();
    chk("fwd v low byp", {31'd0, v_b}, 32'd0);

    // $ra write then single capture and hold
    reg_write  = 1'b1;
    write_reg  = 5'd31;
    write_data = 32'h00400008;
    step();
    reg_write = 1'b0;
    read_reg1 = 5'd31;
    read_reg2 = 5'd29;
    load_ab   = 1'b1;
    step();
    load_ab = 1'b0;
    chk_ab("ra cap", 32'h00400008, 32'd227, 1'b1);
    read_reg1 = 5'd8;
    step();
    chk_ab("ra hold", 32'h00400008, 32'd227, 1'b0);
    step();
    chk_ab("ra hold2", 32'h00400008, 32'd227, 1'b0);

    // reset wins over write and capture
    reg_write  = 1'b1;
    write_reg  = 5'd9;
    write_data = 32'hFFFFFFFF;
    load_ab    = 1'b1;
    reset      = 1'b1;
    read_reg1  = 5'd9;
    read_reg2  = 5'd31;
    step();
    reset     = 1'b0;
    reg_write = 1'b0;
    load_ab   = 1'b0;
    #1;
    chk("mid r9 byp", rd1_b, 32'd0);
    chk("mid r9 nob", rd1_n, 32'd0);
    chk("mid r31 byp", rd2_b, 32'd0);
    chk_ab("mid", 32'd0, 32'd0, 1'b0);

    // fill every register
    reg_write = 1'b1;
    for (int i = 1; i < 32; i++) begin
      write_reg  = 5'(i);
      write_data = 32'(i) * 32'h01010101;
      step();
    end
    reg_write = 1'b0;

    // read pairs with continuous capture
    load_ab = 1'b1;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      e1 = 32'(i) * 32'h01010101;
      e2 = 32'(31 - i) * 32'h01010101;
      #1;
      chk($sformatf("sw r%0d byp", i), rd1_b, e1);
      chk($sformatf("sw r%0d byp", 31 - i), rd2_b, e2);
      chk($sformatf("sw r%0d nob", i), rd1_n, e1);
      chk($sformatf("sw r%0d nob", 31 - i), rd2_n, e2);
      pa = e1;
      pb = e2;
      step();
      chk_ab($sformatf("sw cap %0d", i), pa, pb, 1'b1);
    end
    load_ab = 1'b0;
    step();
    chk_ab("sw end", 32'd31 * 32'h01010101, 32'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
